// File: rtl/aes_block_packer_if.sv
// Handshake bundle between the plaintext byte FIFO, the host flush strobe,
// the block packer and the AES core.
interface aes_block_packer_if;
   logic         fifo_empty;
   logic [7:0]   fifo_rdata;
   logic         fifo_renable;
   logic         flush;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_last;
   logic         busy;

   modport master (
      input  fifo_empty, fifo_rdata, flush, blk_ready,
      output fifo_renable, blk_data, blk_valid, blk_last, busy
   );

   modport slave (
      output fifo_empty, fifo_rdata, flush, blk_ready,
      input  fifo_renable, blk_data, blk_valid, blk_last, busy
   );
endinterface

// File: rtl/aes_block_packer.sv
// Packs FIFO bytes into 128-bit AES blocks, applies PKCS#7 padding on flush
// and presents each block on a valid/ready handshake.
module aes_block_packer (
   input  logic               clk,
   input  logic               n_rst,
   aes_block_packer_if.master bus
);
   typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

   state_t       state;
   logic [4:0]   cnt;
   logic         flush_pending;
   logic [7:0]   pad_val;
   logic [127:0] data_q;
   logic         blk_valid_q;
   logic         blk_last_q;

   logic         pop;
   logic         wr_en;
   logic [7:0]   wr_byte;

   // Pops are suppressed while n_rst is low so the FIFO is never drained in reset.
   assign pop     = n_rst && (state == FILL) && !bus.fifo_empty && (cnt < 5'd16);
   assign wr_en   = pop || (state == PAD);
   assign wr_byte = (state == PAD) ? pad_val : bus.fifo_rdata;

   assign bus.fifo_renable = pop;
   assign bus.blk_data     = data_q;
   assign bus.blk_valid    = blk_valid_q;
   assign bus.blk_last     = blk_last_q;
   assign bus.busy         = (state != FILL) || (cnt != 5'd0) || flush_pending;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state         <= FILL;
         cnt           <= 5'd0;
         flush_pending <= 1'b0;
         pad_val       <= 8'd0;
         data_q        <= '0;
         blk_valid_q   <= 1'b0;
         blk_last_q    <= 1'b0;
      end else begin
         if (bus.flush)
            flush_pending <= 1'b1;

         // Byte slot 0 lands in the most significant byte of the block.
         for (int i = 0; i < 16; i++) begin
            if (wr_en && (cnt[3:0] == 4'(i)))
               data_q[8*(15-i) +: 8] <= wr_byte;
         end

         case (state)
            FILL: begin
               if (pop) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd15) begin
                     state       <= HOLD;
                     blk_valid_q <= 1'b1;
                     blk_last_q  <= 1'b0;
                  end
               end else if (flush_pending && bus.fifo_empty) begin
                  state   <= PAD;
                  pad_val <= {3'b000, 5'd16 - cnt};
               end
            end
            PAD: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  state       <= HOLD;
                  blk_valid_q <= 1'b1;
                  blk_last_q  <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.blk_ready) begin
                  cnt         <= 5'd0;
                  state       <= FILL;
                  blk_valid_q <= 1'b0;
                  // Ends the message; a flush arriving now is a duplicate and is dropped.
                  if (blk_last_q) begin
                     flush_pending <= 1'b0;
                     blk_last_q    <= 1'b0;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: full, padded, aligned, backpressured,
// reset and empty-flush messages against a behavioural FIFO.
module tb_aes_block_packer;
   logic clk = 1'b0;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mem [0:255];
   int   wr_ptr  = 0;
   int   rd_ptr  = 0;
   int   pop_cnt = 0;
   int   cyc;
   int   p0;
   int   vcount;

   aes_block_packer_if ifc ();

   aes_block_packer u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   assign ifc.fifo_empty = (wr_ptr == rd_ptr);
   assign ifc.fifo_rdata = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (ifc.fifo_renable) begin
         rd_ptr  <= rd_ptr + 1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc.blk_valid && n < 100);
   endtask

   initial begin
      n_rst         = 1'b0;
      ifc.flush     = 1'b0;
      ifc.blk_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 128'(ifc.blk_valid), 128'(0));
      check("rst_last", 128'(ifc.blk_last), 128'(0));
      check("rst_data", ifc.blk_data, 128'(0));
      check("rst_renable", 128'(ifc.fifo_renable), 128'(0));
      check("rst_busy", 128'(ifc.busy), 128'(0));
      n_rst = 1'b1;

      // Full block, ready held high
      ifc.blk_ready = 1'b1;
      p0 = pop_cnt;
      for (int i = 0; i < 16; i++) push(8'(i));
      wait_valid(cyc);
      check("full_latency", 128'(cyc), 128'(16));
      check("full_pops", 128'(pop_cnt - p0), 128'(16));
      check("full_data", ifc.blk_data, 128'h000102030405060708090A0B0C0D0E0F);
      check("full_last", 128'(ifc.blk_last), 128'(0));
      @(negedge clk);
      check("full_valid_1cyc", 128'(ifc.blk_valid), 128'(0));
      check("full_busy_idle", 128'(ifc.busy), 128'(0));

      // Partial block then flush
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      wait_valid(cyc);
      check("pad_latency", 128'(cyc), 128'(16));
      check("pad_data", ifc.blk_data, 128'hA0A1A2A3A40B0B0B0B0B0B0B0B0B0B0B);
      check("pad_last", 128'(ifc.blk_last), 128'(1));
      @(negedge clk);
      check("pad_valid_drop", 128'(ifc.blk_valid), 128'(0));
      check("pad_busy_idle", 128'(ifc.busy), 128'(0));

      // Aligned message, flush during HOLD
      ifc.blk_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      wait_valid(cyc);
      check("align_latency", 128'(cyc), 128'(16));
      check("align_data", ifc.blk_data, 128'h101112131415161718191A1B1C1D1E1F);
      check("align_last", 128'(ifc.blk_last), 128'(0));
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      check("align_hold_valid", 128'(ifc.blk_valid), 128'(1));
      check("align_busy", 128'(ifc.busy), 128'(1));
      ifc.blk_ready = 1'b1;
      @(negedge clk);
      check("align_accept", 128'(ifc.blk_valid), 128'(0));
      wait_valid(cyc);
      check("align_pad_latency", 128'(cyc), 128'(17));
      check("align_pad_data", ifc.blk_data, 128'h10101010101010101010101010101010);
      check("align_pad_last", 128'(ifc.blk_last), 128'(1));
      @(negedge clk);
      check("align_valid_drop", 128'(ifc.blk_valid), 128'(0));
      check("align_busy_idle", 128'(ifc.busy), 128'(0));

      // Backpressure with more bytes waiting
      ifc.blk_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      wait_valid(cyc);
      check("bp_latency", 128'(cyc), 128'(16));
      for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
      p0 = pop_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_data_stable", ifc.blk_data, 128'h202122232425262728292A2B2C2D2E2F);
         check("bp_valid_held", 128'(ifc.blk_valid), 128'(1));
         check("bp_no_pop", 128'({ifc.fifo_renable, ifc.fifo_empty}), 128'(0));
      end
      check("bp_pops_held", 128'(pop_cnt - p0), 128'(0));
      ifc.blk_ready = 1'b1;
      @(negedge clk);
      check("bp_accept_no_pop", 128'(pop_cnt - p0), 128'(0));
      repeat (5) @(negedge clk);
      check("bp_resume_pops", 128'(pop_cnt - p0), 128'(5));
      check("bp_fifo_drained", 128'(ifc.fifo_empty), 128'(1));

      // Reset mid-fill with seven bytes packed
      push(8'h35);
      push(8'h36);
      repeat (3) @(negedge clk);
      check("rst_mid_pops", 128'(pop_cnt - p0), 128'(7));
      check("rst_mid_busy", 128'(ifc.busy), 128'(1));
      n_rst = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
      #1;
      check("rst_renable_forced", 128'(ifc.fifo_renable), 128'(0));
      @(negedge clk);
      check("rst_mid_valid", 128'(ifc.blk_valid), 128'(0));
      check("rst_mid_last", 128'(ifc.blk_last), 128'(0));
      check("rst_mid_data", ifc.blk_data, 128'(0));
      check("rst_mid_busy_clr", 128'(ifc.busy), 128'(0));
      check("rst_mid_renable", 128'(ifc.fifo_renable), 128'(0));
      n_rst = 1'b1;
      p0 = pop_cnt;
      wait_valid(cyc);
      check("post_rst_latency", 128'(cyc), 128'(16));
      check("post_rst_data", ifc.blk_data, 128'h404142434445464748494A4B4C4D4E4F);
      check("post_rst_last", 128'(ifc.blk_last), 128'(0));
      @(negedge clk);
      check("post_rst_pops", 128'(pop_cnt - p0), 128'(16));
      check("post_rst_valid_drop", 128'(ifc.blk_valid), 128'(0));

      // Empty flush, with a duplicate flush during PAD
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      check("eflush_busy", 128'(ifc.busy), 128'(1));
      repeat (3) @(negedge clk);
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      wait_valid(cyc);
      check("eflush_latency", 128'(cyc), 128'(13));
      check("eflush_data", ifc.blk_data, 128'h10101010101010101010101010101010);
      check("eflush_last", 128'(ifc.blk_last), 128'(1));
      vcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifc.blk_valid) vcount++;
      end
      check("eflush_no_extra", 128'(vcount), 128'(0));
      check("eflush_busy_idle", 128'(ifc.busy), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
